// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, address split, frame layout and FSM state
// encoding for the 2-way write-back data cache.
//   SETS      number of sets (power of 2)
//   BLKWORDS  words per block (fixed at 2, one block-offset bit)
//   IW / TW   index and tag widths derived from SETS
package dcache_pkg;

  localparam int SETS     = 8;
  localparam int BLKWORDS = 2;
  localparam int IW       = $clog2(SETS);
  localparam int TW       = 32 - IW - 3;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [IW-1:0] idx;
    logic          blkoff;
    logic [1:0]    bytoff;
  } dcachef_t;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TW-1:0]       tag;
    logic [1:0][31:0]    data;
  } dcache_frame_t;

  typedef enum logic [2:0] {
    IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH0, FLUSH1, DONE
  } dcache_state_t;

endpackage

// File: rtl/dcache_array.sv
// dcache_array: frame and LRU storage for both ways.
// Ports:
//   CLK, RST        clock, synchronous active-high reset (clears valid/dirty/LRU)
//   idx             set index shared by the read and write ports
//   frame0/frame1   asynchronous read of both ways at idx
//   lru             LRU bit of set idx (names the least-recently-used way)
//   data_*          one-word data write into way data_way, word data_word
//   meta_*          valid/dirty/tag write into way meta_way
//   lru_*           LRU bit write
module dcache_array
  import dcache_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic [IW-1:0] idx,
  output dcache_frame_t frame0,
  output dcache_frame_t frame1,
  output logic          lru,
  input  logic          data_we,
  input  logic          data_way,
  input  logic          data_word,
  input  logic [31:0]   data_wdata,
  input  logic          meta_we,
  input  logic          meta_way,
  input  logic          meta_valid,
  input  logic          meta_dirty,
  input  logic [TW-1:0] meta_tag,
  input  logic          lru_we,
  input  logic          lru_val
);

  logic [SETS-1:0] valid_q [2];
  logic [SETS-1:0] dirty_q [2];
  logic [SETS-1:0] lru_q;
  logic [TW-1:0]   tag_q   [2][SETS];
  logic [31:0]     data_q  [2][SETS][BLKWORDS];

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      if (meta_we) begin
        valid_q[meta_way][idx] <= meta_valid;
        dirty_q[meta_way][idx] <= meta_dirty;
      end
      if (lru_we) lru_q[idx] <= lru_val;
    end
  end

  // Tags and data need no reset: a frame is only trusted when valid is set.
  always_ff @(posedge CLK) begin
    if (meta_we) tag_q[meta_way][idx] <= meta_tag;
    if (data_we) data_q[data_way][idx][data_word] <= data_wdata;
  end

  always_comb begin
    frame0.valid   = valid_q[0][idx];
    frame0.dirty   = dirty_q[0][idx];
    frame0.tag     = tag_q[0][idx];
    frame0.data[0] = data_q[0][idx][0];
    frame0.data[1] = data_q[0][idx][1];
    frame1.valid   = valid_q[1][idx];
    frame1.dirty   = dirty_q[1][idx];
    frame1.tag     = tag_q[1][idx];
    frame1.data[0] = data_q[1][idx][0];
    frame1.data[1] = data_q[1][idx][1];
  end

  assign lru = lru_q[idx];

endmodule

// File: rtl/dcache.sv
// dcache: write-back 2-way set-associative data cache with word-serial
// memory port and halt-triggered flush.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   halt                           start flush (sampled in IDLE)
//   dmemREN/dmemWEN/dmemaddr/dmemstore  pipeline request (store wins)
//   dhit/dmemload                  request completes / load data
//   flushed                        flush finished, sticky until RST
//   dREN/dWEN/daddr/dstore         memory request
//   dwait/dload                    memory busy / memory read data
//
// state  | meaning
// IDLE   | serve hits combinationally; start miss or flush
// WB0    | write back victim word 0
// WB1    | write back victim word 1
// FETCH0 | read requested block word 0
// FETCH1 | read word 1, then install frame
// FLUSH0 | examine flush frame; write word 0 if dirty, else skip
// FLUSH1 | write word 1 of dirty flush frame, clear dirty
// DONE   | flush complete, requests ignored
module dcache
  import dcache_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  dcache_state_t state, next;
  dcachef_t      req;
  dcache_frame_t f0, f1, cand, vframe, fframe;
  logic          lru, vway, vsel, hit0, hit1, req_v, miss_start, fcnt_adv;
  logic [IW:0]   fcnt;
  logic [IW-1:0] idx;
  logic          unused_bytoff;

  logic          data_we, data_way, data_word, meta_we, meta_way;
  logic          meta_valid, meta_dirty, lru_we, lru_val;
  logic [31:0]   data_wdata;
  logic [TW-1:0] meta_tag;

  assign req           = dcachef_t'(dmemaddr);
  assign unused_bytoff = ^req.bytoff;

  // Flush counter layout is {set, way} so way 0 of a set is visited first.
  assign idx = (state == FLUSH0 || state == FLUSH1) ? fcnt[IW:1] : req.idx;

  dcache_array u_array (
    .CLK        (CLK),
    .RST        (RST),
    .idx        (idx),
    .frame0     (f0),
    .frame1     (f1),
    .lru        (lru),
    .data_we    (data_we),
    .data_way   (data_way),
    .data_word  (data_word),
    .data_wdata (data_wdata),
    .meta_we    (meta_we),
    .meta_way   (meta_way),
    .meta_valid (meta_valid),
    .meta_dirty (meta_dirty),
    .meta_tag   (meta_tag),
    .lru_we     (lru_we),
    .lru_val    (lru_val)
  );

  assign hit0   = f0.valid && (f0.tag == req.tag);
  assign hit1   = f1.valid && (f1.tag == req.tag);
  assign req_v  = dmemREN || dmemWEN;
  assign vsel   = !f0.valid ? 1'b0 : (!f1.valid ? 1'b1 : lru);
  assign cand   = vsel ? f1 : f0;
  assign vframe = vway ? f1 : f0;
  assign fframe = fcnt[0] ? f1 : f0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      vway  <= 1'b0;
      fcnt  <= '0;
    end else begin
      state <= next;
      if (miss_start) vway <= vsel;
      if (state == IDLE) fcnt <= '0;
      else if (fcnt_adv) fcnt <= fcnt + 1'b1;
    end
  end

  always_comb begin
    next       = state;
    dhit       = 1'b0;
    dmemload   = '0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    daddr      = '0;
    dstore     = '0;
    flushed    = (state == DONE);
    miss_start = 1'b0;
    fcnt_adv   = 1'b0;
    data_we    = 1'b0;
    data_way   = vway;
    data_word  = 1'b0;
    data_wdata = dload;
    meta_we    = 1'b0;
    meta_way   = vway;
    meta_valid = 1'b1;
    meta_dirty = 1'b0;
    meta_tag   = req.tag;
    lru_we     = 1'b0;
    lru_val    = 1'b0;
    case (state)
      IDLE: begin
        if (halt) begin
          next = FLUSH0;
        end else if (req_v && !RST) begin
          if (hit0 || hit1) begin
            dhit     = 1'b1;
            dmemload = hit1 ? f1.data[req.blkoff] : f0.data[req.blkoff];
            lru_we   = 1'b1;
            lru_val  = ~hit1;
            if (dmemWEN) begin
              data_we    = 1'b1;
              data_way   = hit1;
              data_word  = req.blkoff;
              data_wdata = dmemstore;
              meta_we    = 1'b1;
              meta_way   = hit1;
              meta_dirty = 1'b1;
            end
          end else begin
            miss_start = 1'b1;
            next       = (cand.valid && cand.dirty) ? WB0 : FETCH0;
          end
        end
      end
      WB0, WB1: begin
        dWEN   = 1'b1;
        daddr  = {vframe.tag, req.idx, (state == WB1), 2'b00};
        dstore = vframe.data[state == WB1];
        if (!dwait) next = (state == WB0) ? WB1 : FETCH0;
      end
      FETCH0, FETCH1: begin
        dREN      = 1'b1;
        daddr     = {req.tag, req.idx, (state == FETCH1), 2'b00};
        data_word = (state == FETCH1);
        if (!dwait) begin
          data_we = 1'b1;
          if (state == FETCH0) begin
            next = FETCH1;
          end else begin
            meta_we = 1'b1;
            next    = IDLE;
          end
        end
      end
      FLUSH0: begin
        if (fframe.valid && fframe.dirty) begin
          dWEN   = 1'b1;
          daddr  = {fframe.tag, fcnt[IW:1], 1'b0, 2'b00};
          dstore = fframe.data[0];
          if (!dwait) next = FLUSH1;
        end else begin
          fcnt_adv = 1'b1;
          if (&fcnt) next = DONE;
        end
      end
      FLUSH1: begin
        dWEN   = 1'b1;
        daddr  = {fframe.tag, fcnt[IW:1], 1'b1, 2'b00};
        dstore = fframe.data[1];
        if (!dwait) begin
          meta_we    = 1'b1;
          meta_way   = fcnt[0];
          meta_valid = fframe.valid;
          meta_tag   = fframe.tag;
          fcnt_adv   = 1'b1;
          next       = (&fcnt) ? DONE : FLUSH0;
        end
      end
      DONE: next = DONE;
      default: next = IDLE;
    endcase
  end

endmodule
